// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register rename status
// (busy bit + ROB tag) for a Tomasulo/ROB core.
//
// Reads are combinational: each port returns either a ready operand or the ROB
// tag to wait on. Dispatch allocates destinations, ROB commit writes values back
// and releases renames, and flush drops every rename.
//
// Optional feature macro: RF_CDB_BYPASS_EN
//   defined   - a busy register whose tag matches the current CDB broadcast is
//               read as ready with cdb_data.
//   undefined - cdb_* inputs are accepted but ignored.
//
// Reset is synchronous, active-high (rst). All state updates are gated by rdy.
module regfile_rename #(
  parameter int NREG  = 32,
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD-1:0]       rd_valid,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD*TAG_W-1:0] rd_tag,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_addr,
  input  logic [TAG_W-1:0]     alloc_tag,
  input  logic                 commit_valid,
  input  logic [AW-1:0]        commit_addr,
  input  logic [TAG_W-1:0]     commit_tag,
  input  logic [XLEN-1:0]      commit_data,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [XLEN-1:0]      cdb_data,
  input  logic                 flush
);

  logic [XLEN-1:0]  r_regs [NREG];
  logic [TAG_W-1:0] r_tags [NREG];
  logic [NREG-1:0]  r_busy;

  logic [AW-1:0]    w_addr [NRD];

`ifndef RF_CDB_BYPASS_EN
  // The CDB is snooped by the reservation stations instead; keep the inputs
  // visibly consumed so they remain part of the interface.
  logic w_cdb_unused;
  assign w_cdb_unused = ^{cdb_valid, cdb_tag, cdb_data};
`endif

  // Commit first, then alloc/flush, so a same-cycle alloc overrides the
  // commit's busy release on the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
        r_tags[r] <= '0;
      end
    end else if (rdy) begin
      if (commit_valid && (commit_addr != '0)) begin
        r_regs[commit_addr] <= commit_data;
        // A stale commit (older tag) must not release a newer rename.
        if (r_tags[commit_addr] == commit_tag) begin
          r_busy[commit_addr] <= 1'b0;
        end
      end
      if (flush) begin
        r_busy <= '0;
      end else if (alloc_valid && (alloc_addr != '0)) begin
        r_busy[alloc_addr] <= 1'b1;
        r_tags[alloc_addr] <= alloc_tag;
      end
    end
  end

  // Split the packed address bus into one address per read port.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      w_addr[i] = rd_addr[i*AW +: AW];
    end
  end

  // Per-port operand lookup against pre-update state: ready value, same-cycle
  // commit forward, optional CDB forward, otherwise the tag to wait on.
  always_comb begin
    rd_valid = '0;
    rd_busy  = '0;
    rd_data  = '0;
    rd_tag   = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_en[i] && !rst) begin
        rd_valid[i] = 1'b1;
        if (w_addr[i] != '0) begin
          if (!r_busy[w_addr[i]]) begin
            rd_data[i*XLEN +: XLEN] = r_regs[w_addr[i]];
          end else if (commit_valid && (commit_addr == w_addr[i]) &&
                       (commit_tag == r_tags[w_addr[i]])) begin
            rd_data[i*XLEN +: XLEN] = commit_data;
`ifdef RF_CDB_BYPASS_EN
          end else if (cdb_valid && (cdb_tag == r_tags[w_addr[i]])) begin
            rd_data[i*XLEN +: XLEN] = cdb_data;
`endif
          end else begin
            rd_busy[i]               = 1'b1;
            rd_tag[i*TAG_W +: TAG_W] = r_tags[w_addr[i]];
          end
        end
      end
    end
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Parametrised architectural register file with per-register rename status (busy bit + ROB tag) for the Tomasulo/ROB core.
- Sits between decode/dispatch and the ROB.
- Serves NRD read ports per cycle. Each port returns either a ready value or the ROB tag to wait on.
- Decode allocates destinations; ROB commit writes values back and releases rename entries; flush clears all renames.

Parameters:
NREG, 32, number of architectural registers (power of two); AW = $clog2(NREG) derived localparam
XLEN, 32, data width
TAG_W, 4, ROB tag width
NRD, 2, number of read ports

Ports:
clk  input  1  clock
rst  input  1  reset
rdy  input  1  global enable; state frozen when low
rd_en  input  NRD  per-port read request
rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_valid  output  NRD  port result meaningful (= rd_en && !rst)
rd_busy  output  NRD  1: operand pending, wait on rd_tag
rd_data  output  NRD*XLEN  operand value when !rd_busy, else 0
rd_tag  output  NRD*TAG_W  producing ROB tag when rd_busy, else 0
alloc_valid  input  1  rename destination this cycle
alloc_addr  input  AW  destination register
alloc_tag  input  TAG_W  ROB entry assigned
commit_valid  input  1  ROB commit this cycle
commit_addr  input  AW  committed destination
commit_tag  input  TAG_W  committing ROB entry
commit_data  input  XLEN  committed value
cdb_valid  input  1  common data bus broadcast
cdb_tag  input  TAG_W  broadcast tag
cdb_data  input  XLEN  broadcast value
flush  input  1  mispredict flush; drop all renames

Behaviour:
- Reset: rst is synchronous, active-high, on clk. On a rst cycle, all regs, busy and tags are cleared to 0. While rst is high, all outputs are 0.
- Reads are combinational, zero latency. Each port is independent, and ports use correct per-port addressing; every port indexes its own rd_addr slice.
- Port with rd_en=0: rd_valid=0; busy, data and tag are 0.
- rd_addr=0: value 0, not busy, regardless of state.
- Read priority, per port, for reg r:
  1. If !busy[r]: return regs[r].
  2. Else if commit_valid && commit_addr==r && commit_tag==tags[r]: return commit_data, not busy.
  3. Else if CDB bypass (see Optional Feature) hits: return cdb_data, not busy.
  4. Else: busy, with rd_tag = tags[r].
- Reads never see a same-cycle alloc. An instruction's own sources read the pre-rename state.
- Reads ignore a same-cycle flush.
- Sequential updates happen only when rdy=1 and rst=0:
  - Commit with commit_addr!=0: regs[addr] <= commit_data. busy[addr] is cleared only if tags[addr]==commit_tag; a stale commit leaves busy/tag untouched.
  - Alloc with alloc_addr!=0: busy[addr] <= 1, tags[addr] <= alloc_tag. Alloc to x0 is ignored.
  - Alloc and commit to the same addr in one cycle: data written, busy stays 1, tag = alloc_tag (alloc wins).
  - flush: all busy <= 0, and alloc is ignored that cycle. A commit in the same cycle still writes regs.
- rdy=0: no state change; combinational reads remain live.
- Tags are not interpreted beyond equality; tag wrap-around is the ROB's responsibility.

Optional Feature:
- Macro: RF_CDB_BYPASS_EN.
- Defined: a read of busy reg r with cdb_valid && cdb_tag==tags[r] returns cdb_data, not busy. This closes the broadcast-vs-dispatch race.
- Undefined: there is no CDB bypass. cdb_* ports remain present but are ignored, and the port reports busy with the tag; the reservation station must snoop the CDB itself.

Test Plan:
- Reset, then read x5 and x0 on both ports -> rd_valid=1, rd_busy=0, rd_data=0.
- Alloc x5 tag 3; next cycle read x5 -> busy=1, tag=3. Same-cycle read during alloc -> busy=0, data=0.
- x5 busy tag 3; commit x5 tag 3 data 0xDEADBEEF -> same-cycle read returns 0xDEADBEEF not busy; next cycle busy=0, data=0xDEADBEEF.
- x5 realloc tag 7, then commit x5 tag 3 data 0x11 -> regs=0x11, read still busy tag 7. Alloc x6 tag 2 together with commit x6 tag 1 -> busy, tag 2.
- Busy x5/x6, flush plus alloc x7 tag 4 -> next cycle all not busy, x7 not renamed. rdy=0 during alloc -> no change.
- With RF_CDB_BYPASS_EN: x9 busy tag 5, cdb tag 5 data 0x42 -> read 0x42 not busy. Without the macro -> busy, tag 5.
